arbitro_memoria_dados: RTL and testbench

ARBITRO_MEMORIA_DADOS -- requirements
Module: arbitro_memoria_dados

---
 rtl/arbitro_memoria_dados.sv | 136 +++++++++++++
 tb/tb_arbitro_memoria_dados.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_memoria_dados.sv
// rtl/arbitro_memoria_dados.sv - two-port data memory arbiter, 3-state access FSM
// Optional macro ARBITRO_PRIORIDADE_FIXA_EN: port 0 always wins conflicts (default: round-robin).
module arbitro_memoria_dados (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Req0,
   input  logic       Req1,
   input  logic       Esc0,
   input  logic       Esc1,
   input  logic [7:0] End0,
   input  logic [7:0] End1,
   input  logic [7:0] Dado0,
   input  logic [7:0] Dado1,
   output logic       Pronto0,
   output logic       Pronto1,
   output logic [7:0] Lido0,
   output logic [7:0] Lido1,
   output logic [7:0] EnderecoMem,
   output logic [7:0] DadoEscritoMem,
   output logic       EscMem,
   output logic       LerMem,
   input  logic [7:0] DadoLidoMem,
   output logic       Ocupado
);

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      ACESSO   = 2'd1,
      RESPOSTA = 2'd2
   } estado_t;

   estado_t    estado_q, estado_d;
   logic       porta_q, porta_d;
   logic       esc_q, esc_d;
   logic [7:0] end_q, end_d;
   logic [7:0] dado_q, dado_d;
   logic [7:0] lido0_q, lido0_d;
   logic [7:0] lido1_q, lido1_d;
   logic       vence;

`ifdef ARBITRO_PRIORIDADE_FIXA_EN
   always_comb begin
      vence = ~Req0;
   end
`else
   logic prio_q, prio_d;

   // prio_q names the port that wins the next simultaneous request
   always_comb begin
      vence = (Req0 && Req1) ? prio_q : Req1;
   end

   always_comb begin
      prio_d = prio_q;
      if (estado_q == OCIOSO && (Req0 || Req1)) begin
         prio_d = ~vence;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end
`endif

   always_comb begin
      estado_d = estado_q;
      porta_d  = porta_q;
      esc_d    = esc_q;
      end_d    = end_q;
      dado_d   = dado_q;
      lido0_d  = lido0_q;
      lido1_d  = lido1_q;
      case (estado_q)
         OCIOSO: begin
            if (Req0 || Req1) begin
               estado_d = ACESSO;
               porta_d  = vence;
               esc_d    = vence ? Esc1 : Esc0;
               end_d    = vence ? End1 : End0;
               dado_d   = vence ? Dado1 : Dado0;
            end
         end
         ACESSO: begin
            estado_d = RESPOSTA;
            if (!esc_q) begin
               if (porta_q) begin
                  lido1_d = DadoLidoMem;
               end else begin
                  lido0_d = DadoLidoMem;
               end
            end
         end
         RESPOSTA: begin
            estado_d = OCIOSO;
         end
         default: begin
            estado_d = OCIOSO;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         estado_q <= OCIOSO;
         porta_q  <= 1'b0;
         esc_q    <= 1'b0;
         end_q    <= 8'h00;
         dado_q   <= 8'h00;
         lido0_q  <= 8'h00;
         lido1_q  <= 8'h00;
      end else begin
         estado_q <= estado_d;
         porta_q  <= porta_d;
         esc_q    <= esc_d;
         end_q    <= end_d;
         dado_q   <= dado_d;
         lido0_q  <= lido0_d;
         lido1_q  <= lido1_d;
      end
   end

   assign EnderecoMem    = end_q;
   assign DadoEscritoMem = dado_q;
   assign EscMem         = (estado_q == ACESSO) &&  esc_q;
   assign LerMem         = (estado_q == ACESSO) && !esc_q;
   assign Pronto0        = (estado_q == RESPOSTA) && !porta_q;
   assign Pronto1        = (estado_q == RESPOSTA) &&  porta_q;
   assign Ocupado        = (estado_q != OCIOSO);
   assign Lido0          = lido0_q;
   assign Lido1          = lido1_q;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// tb/tb_arbitro_memoria_dados.sv - directed plus random bench for arbitro_memoria_dados
// Honours ARBITRO_PRIORIDADE_FIXA_EN the same way as the design.
module tb_arbitro_memoria_dados;

   logic       Clock, Reset;
   logic       Req0, Req1, Esc0, Esc1;
   logic [7:0] End0, End1, Dado0, Dado1;
   logic       Pronto0, Pronto1;
   logic [7:0] Lido0, Lido1, EnderecoMem, DadoEscritoMem, DadoLidoMem;
   logic       EscMem, LerMem, Ocupado;

   int n_tests = 0;
   int n_fail  = 0;

   arbitro_memoria_dados dut (
      .Clock(Clock), .Reset(Reset),
      .Req0(Req0), .Req1(Req1), .Esc0(Esc0), .Esc1(Esc1),
      .End0(End0), .End1(End1), .Dado0(Dado0), .Dado1(Dado1),
      .Pronto0(Pronto0), .Pronto1(Pronto1), .Lido0(Lido0), .Lido1(Lido1),
      .EnderecoMem(EnderecoMem), .DadoEscritoMem(DadoEscritoMem),
      .EscMem(EscMem), .LerMem(LerMem), .DadoLidoMem(DadoLidoMem),
      .Ocupado(Ocupado)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   logic [7:0] mem     [256];
   logic [7:0] ref_mem [256];

   // Environment memory: reacts to the DUT strobes, read data valid after the falling edge
   always @(negedge Clock) begin
      if (EscMem === 1'b1) mem[EnderecoMem] = DadoEscritoMem;
      if (LerMem === 1'b1) DadoLidoMem = mem[EnderecoMem];
      else                 DadoLidoMem = 8'($urandom);
   end

   // Transaction-level reference: cycles_left counts down the two cycles after a grant
   int         cycles_left = 0;
   bit         ptr = 1'b0;
   bit         model_live = 1'b0;
   bit         m_port, m_write, gp;
   logic [7:0] m_addr, m_data, e_lido0, e_lido1;

   always @(posedge Clock) begin
      if (Reset) begin
         cycles_left = 0; ptr = 1'b0; e_lido0 = 8'h00; e_lido1 = 8'h00;
         m_port = 1'b0; m_write = 1'b0; m_addr = 8'h00; m_data = 8'h00;
         model_live = 1'b1;
      end else if (cycles_left == 2) begin
         cycles_left = 1;
         if (!m_write) begin
            if (m_port) e_lido1 = ref_mem[m_addr];
            else        e_lido0 = ref_mem[m_addr];
         end
      end else if (cycles_left == 1) begin
         cycles_left = 0;
      end else if (Req0 || Req1) begin
`ifdef ARBITRO_PRIORIDADE_FIXA_EN
         gp = !Req0;
`else
         gp  = (Req0 && Req1) ? ptr : Req1;
         ptr = !gp;
`endif
         m_port  = gp;
         m_write = gp ? Esc1 : Esc0;
         m_addr  = gp ? End1 : End0;
         m_data  = gp ? Dado1 : Dado0;
         if (m_write) ref_mem[m_addr] = m_data;
         cycles_left = 2;
      end
   end

   task automatic chk(input string nome, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", nome, act, exp, $time);
      end
   endtask

   always @(negedge Clock) begin
      if (model_live) begin
         chk("Ocupado", {7'b0, Ocupado}, {7'b0, cycles_left != 0});
         chk("EscMem",  {7'b0, EscMem},  {7'b0, cycles_left == 2 &&  m_write});
         chk("LerMem",  {7'b0, LerMem},  {7'b0, cycles_left == 2 && !m_write});
         chk("Pronto0", {7'b0, Pronto0}, {7'b0, cycles_left == 1 && !m_port});
         chk("Pronto1", {7'b0, Pronto1}, {7'b0, cycles_left == 1 &&  m_port});
         chk("Lido0", Lido0, e_lido0);
         chk("Lido1", Lido1, e_lido1);
         if (cycles_left == 2) begin
            chk("EnderecoMem", EnderecoMem, m_addr);
            if (m_write) chk("DadoEscritoMem", DadoEscritoMem, m_data);
         end
      end
   end

   task automatic cyc;
      @(posedge Clock);
      #1;
   endtask

   int exp_ord [4];

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'(i) ^ 8'h5A;
         ref_mem[i] = 8'(i) ^ 8'h5A;
      end
      mem[8'h20] = 8'h3C; ref_mem[8'h20] = 8'h3C;
      Reset = 1'b1; Req0 = 0; Req1 = 0; Esc0 = 0; Esc1 = 0;
      End0 = 0; End1 = 0; Dado0 = 0; Dado1 = 0;
      cyc; cyc;
      chk("rst_Ocupado", {7'b0, Ocupado}, 8'h00);
      chk("rst_Pronto0", {7'b0, Pronto0}, 8'h00);
      chk("rst_Lido0", Lido0, 8'h00);
      chk("rst_Endereco", EnderecoMem, 8'h00);
      Reset = 1'b0;

      // Basic write from port 0
      Req0 = 1; Esc0 = 1; End0 = 8'h10; Dado0 = 8'hA5;
      cyc;
      chk("wr_EscMem", {7'b0, EscMem}, 8'h01);
      chk("wr_Endereco", EnderecoMem, 8'h10);
      chk("wr_Dado", DadoEscritoMem, 8'hA5);
      cyc;
      chk("wr_Pronto0", {7'b0, Pronto0}, 8'h01);
      Req0 = 0;
      cyc;

      // Port 1 read of a preloaded location
      Req1 = 1; Esc1 = 0; End1 = 8'h20;
      cyc;
      chk("rd_LerMem", {7'b0, LerMem}, 8'h01);
      cyc;
      chk("rd_Pronto1", {7'b0, Pronto1}, 8'h01);
      chk("rd_Lido1", Lido1, 8'h3C);
      chk("rd_Lido0", Lido0, 8'h00);
      Req1 = 0;
      cyc;

      // Inputs changed after grant do not disturb the access
      Req0 = 1; Esc0 = 1; End0 = 8'h30; Dado0 = 8'h5A;
      cyc;
      End0 = 8'hFF; Req0 = 0;
      #2;
      chk("latch_Endereco", EnderecoMem, 8'h30);
      cyc;
      chk("latch_Pronto0", {7'b0, Pronto0}, 8'h01);
      cyc;

      // Simultaneous held requests from a fresh reset
      Reset = 1; cyc; Reset = 0;
`ifdef ARBITRO_PRIORIDADE_FIXA_EN
      exp_ord = '{0, 0, 0, 0};
`else
      exp_ord = '{0, 1, 0, 1};
`endif
      Req0 = 1; Req1 = 1; Esc0 = 0; Esc1 = 0; End0 = 8'h01; End1 = 8'h02;
      for (int g = 0; g < 4; g++) begin
         int k;
         k = 0;
         cyc;
         while (!(Pronto0 || Pronto1) && k < 10) begin
            cyc;
            k++;
         end
         if (k >= 10) begin
            n_tests++; n_fail++;
            $display("FAIL grant_timeout: no Pronto for grant %0d, expected one within 10 cycles", g);
         end else begin
            chk("grant_order", {7'b0, Pronto1}, 8'(exp_ord[g]));
         end
      end
      Req0 = 0; Req1 = 0;
      cyc; cyc; cyc;

      // Reset in the middle of a write
      Reset = 1; cyc; Reset = 0;
      Req0 = 1; Esc0 = 1; End0 = 8'h40; Dado0 = 8'h77;
      cyc;
      chk("abort_EscMem_before", {7'b0, EscMem}, 8'h01);
      Reset = 1;
      cyc;
      Reset = 0;
      chk("abort_Pronto0", {7'b0, Pronto0}, 8'h00);
      chk("abort_EscMem", {7'b0, EscMem}, 8'h00);
      chk("abort_Ocupado", {7'b0, Ocupado}, 8'h00);
      chk("abort_Endereco", EnderecoMem, 8'h00);
      cyc;
      chk("retry_Endereco", EnderecoMem, 8'h40);
      cyc;
      chk("retry_Pronto0", {7'b0, Pronto0}, 8'h01);
      Req0 = 0;
      cyc;

      // Random traffic against the reference
      for (int n = 0; n < 3000; n++) begin
         Reset = ($urandom_range(0, 99) == 0);
         Req0  = ($urandom_range(0, 2) != 0);
         Req1  = ($urandom_range(0, 2) != 0);
         Esc0  = 1'($urandom);
         Esc1  = 1'($urandom);
         End0  = 8'($urandom_range(0, 15));
         End1  = 8'($urandom_range(0, 15));
         Dado0 = 8'($urandom);
         Dado1 = 8'($urandom);
         cyc;
      end
      Reset = 0; Req0 = 0; Req1 = 0;
      cyc; cyc; cyc;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
